// File: rtl/datapath_core_pkg.sv
// -----------------------------------------------------------------------------
// datapath_core_pkg
//   Shared definitions for the registered adder datapath.
//   DATA_W : default operand/result width in bits.
//   word_t : one operand/result word of DATA_W bits.
// -----------------------------------------------------------------------------
package datapath_core_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

endpackage : datapath_core_pkg

// File: rtl/datapath_core_if.sv
// -----------------------------------------------------------------------------
// datapath_core_if
//   Operand/result bundle between the upstream operand registers, the adder
//   core and its downstream consumers.
//   input1 : operand A (driven by master)
//   input2 : operand B (driven by master)
//   out    : registered sum (driven by slave)
//   Modports: master = operand source / result sink, slave = adder core.
// -----------------------------------------------------------------------------
interface datapath_core_if
    import datapath_core_pkg::*;
#(
    parameter int WIDTH = DATA_W
);

    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] out;

    modport master (
        output input1,
        output input2,
        input  out
    );

    modport slave (
        input  input1,
        input  input2,
        output out
    );

endinterface : datapath_core_if

// File: rtl/datapath_core_add_unit.sv
// -----------------------------------------------------------------------------
// add_unit
//   Purely combinational WIDTH-bit unsigned adder built from 4-bit
//   carry-lookahead blocks. Block-level generate/propagate terms chain the
//   carry from one block to the next.
//   a, b : operands
//   sum  : (a + b) mod 2^WIDTH
//   cout : carry out of the most significant bit
// -----------------------------------------------------------------------------
module add_unit
    import datapath_core_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Operands are zero-padded up to a whole number of 4-bit blocks; the pad
    // bits have g = p = 0, so they never disturb the real carry chain.
    localparam int NBLK = (WIDTH + 3) / 4;
    localparam int PW   = NBLK * 4;

    logic [PW-1:0] a_pad;
    logic [PW-1:0] b_pad;
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW:0]   c;      // c[i] = carry into bit i
    logic [PW-1:0] s;
    logic          blk_g;
    logic          blk_p;
    logic          carry;  // carry into the block currently being evaluated

    assign a_pad = PW'(a);
    assign b_pad = PW'(b);

    always_comb begin
        g     = a_pad & b_pad;
        p     = a_pad ^ b_pad;
        c     = '0;
        blk_g = 1'b0;
        blk_p = 1'b0;
        carry = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            // In-block lookahead: every internal carry comes straight from
            // the block carry-in and the bit g/p terms.
            c[4*k]   = carry;
            c[4*k+1] = g[4*k]
                     | (p[4*k] & carry);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & carry);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
            blk_g    = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            blk_p    = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            carry    = blk_g | (blk_p & carry);
        end
        c[PW] = carry;
        s     = p ^ c[PW-1:0];
    end

    assign sum  = s[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule : add_unit

// File: rtl/datapath_core.sv
// -----------------------------------------------------------------------------
// datapath_core
//   Registered WIDTH-bit adder: bus.out <= (bus.input1 + bus.input2) mod
//   2^WIDTH on every rising clk edge. One-cycle latency, one result per cycle,
//   no handshake. The carry-out is dropped, so signed two's-complement sums
//   wrap naturally; there is no saturation and no overflow flag.
//   clk   : system clock, rising-edge active
//   reset : asynchronous, active-low; clears out to 0 immediately
//   bus   : slave side of datapath_core_if (input1, input2 in; out out)
// -----------------------------------------------------------------------------
module datapath_core
    import datapath_core_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic            clk,
    input  logic            reset,
    datapath_core_if.slave  bus
);

    logic [WIDTH-1:0] sum_p0;
    logic             add_cout_unused;
    logic [WIDTH-1:0] out_p1_d;
    logic [WIDTH-1:0] out_p1_q;

    // ---- stage p0: combinational add of the current operands ----
    add_unit #(
        .WIDTH (WIDTH)
    ) u_add_unit (
        .a    (bus.input1),
        .b    (bus.input2),
        .sum  (sum_p0),
        .cout (add_cout_unused)
    );

    always_comb begin
        out_p1_d = sum_p0;
    end

    // ---- stage p1: output register, the only path to bus.out ----
    // The result register is cleared by reset so an in-flight sum is
    // discarded and downstream consumers see 0 while held in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_p1_q <= '0;
        end else begin
            out_p1_q <= out_p1_d;
        end
    end

    assign bus.out = out_p1_q;

endmodule : datapath_core

// File: tb/tb_datapath_core.sv
// -----------------------------------------------------------------------------
// tb_datapath_core
//   Directed and randomized bench for datapath_core. Operands are driven 1 ns
//   after a rising edge and results are sampled 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_datapath_core;
    import datapath_core_pkg::*;

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    word_t exp_q[$];

    datapath_core_if #(.WIDTH(DATA_W)) bus ();

    datapath_core #(.WIDTH(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide-integer addition reduced modulo 2^32.
    function automatic word_t ref_add(input word_t a, input word_t b);
        longint unsigned full;
        full = longint'(a) + longint'(b);
        return word_t'(full % (64'd1 << DATA_W));
    endfunction

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input word_t a, input word_t b);
        bus.input1 = a;
        bus.input2 = b;
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    word_t a_tbl [3];
    word_t b_tbl [3];
    word_t e_tbl [3];
    word_t ra;
    word_t rb;

    initial begin
        reset = 1'b1;
        drive(32'h0000_1234, 32'h0000_5678);
        #2;
        reset = 1'b0;
        #1;
        check("reset_async_clear", bus.out, 32'h0);

        // Held in reset: inputs ignored for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_hold", bus.out, 32'h0);
        end

        // Release away from the edge; out stays 0 until the next edge.
        reset = 1'b1;
        drive(32'd1, 32'd2);
        #1;
        check("release_before_edge", bus.out, 32'h0);
        tick();
        check("first_sum", bus.out, 32'd3);

        // Back-to-back operand pairs.
        a_tbl = '{32'd3, 32'd5, 32'd7};
        b_tbl = '{32'd4, 32'd6, 32'd8};
        e_tbl = '{32'd7, 32'd11, 32'd15};
        for (int i = 0; i < 3; i++) begin
            drive(a_tbl[i], b_tbl[i]);
            tick();
            check("back_to_back", bus.out, e_tbl[i]);
        end

        // Modulo wrap boundaries.
        drive(32'hFFFF_FFFF, 32'h0000_0001);
        tick();
        check("wrap_all_ones", bus.out, 32'h0000_0000);
        drive(32'h8000_0000, 32'h8000_0000);
        tick();
        check("wrap_msb_pair", bus.out, 32'h0000_0000);
        drive(32'h7FFF_FFFF, 32'h0000_0001);
        tick();
        check("signed_overflow", bus.out, 32'h8000_0000);

        // Operands change between edges: only the value at the edge counts.
        drive(32'd1000, 32'd2000);
        #3;
        drive(32'd7, 32'd8);
        tick();
        check("mid_cycle_change", bus.out, 32'd15);

        // Reset dropped mid-cycle clears out before the next edge.
        #4;
        check("steady_before_reset", bus.out, 32'd15);
        drive(32'd10, 32'd20);
        reset = 1'b0;
        #1;
        check("reset_mid_cycle", bus.out, 32'h0);
        tick();
        check("reset_mid_hold", bus.out, 32'h0);
        reset = 1'b1;
        #1;
        check("release_mid_cycle", bus.out, 32'h0);
        tick();
        check("after_release_sum", bus.out, 32'd30);

        // Randomized regression against the reference model.
        for (int i = 0; i < 1000; i++) begin
            ra = word_t'($urandom);
            rb = word_t'($urandom);
            if (i % 100 == 0) ra = 32'hFFFF_FFFF;
            drive(ra, rb);
            exp_q.push_back(ref_add(ra, rb));
            tick();
            check("random", bus.out, exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_datapath_core
